// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults, minimum synchroniser depth and counter-limit helpers for debounce_bank
package debounce_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_W = 11;
  localparam int DEF_HOLD_W = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACTIVE_LOW = 0;
  localparam int MIN_SYNC_STAGES = 2;
  function automatic int stable_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction
  function automatic int hold_max(input int hold_w);
    return (1 << hold_w) - 1;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-input synchroniser, stable filter, hold timer and pulses (in clk n_reset tick button_in; out db_out rise fall hold)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic tick,
  input  logic button_in,
  output logic db_out,
  output logic rise,
  output logic fall,
  output logic hold
);
  localparam int SN = SYNC_STAGES < MIN_SYNC_STAGES ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(stable_max(CNT_W));
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(hold_max(HOLD_W));
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(hold_max(HOLD_W) - 1);
  logic [SN-1:0] sync;
  logic s, s_prev, commit;
  logic [CNT_W-1:0] cnt;
  logic [HOLD_W-1:0] hold_cnt;
  assign s = sync[SN-1];
  assign commit = cnt == STABLE_MAX && s == s_prev && s != db_out;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync <= '0;
      s_prev <= 1'b0;
      cnt <= '0;
      hold_cnt <= '0;
      db_out <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      hold <= 1'b0;
    end else begin
      sync <= {sync[SN-2:0], button_in ^ ACTIVE_LOW};
      s_prev <= s;
      cnt <= s != s_prev ? '0 : tick && cnt != STABLE_MAX ? cnt + 1'b1 : cnt;
      db_out <= commit ? s : db_out;
      rise <= commit && s;
      fall <= commit && !s;
      hold_cnt <= !db_out ? '0 : tick && hold_cnt != HOLD_MAX ? hold_cnt + 1'b1 : hold_cnt;
      hold <= db_out && tick && hold_cnt == HOLD_LAST && !commit;
    end
  end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debounce channels sharing tick (in clk n_reset tick button_in; out db_out rise fall hold)
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .CNT_W(CNT_W),
      .HOLD_W(HOLD_W),
      .SYNC_STAGES(SYNC_STAGES),
      .ACTIVE_LOW(ACTIVE_LOW != 0)
    ) u_ch (
      .clk(clk),
      .n_reset(n_reset),
      .tick(tick),
      .button_in(button_in[g]),
      .db_out(db_out[g]),
      .rise(rise[g]),
      .fall(fall[g]),
      .hold(hold[g])
    );
  end
endmodule
